// File: rtl/multiplier_pkg.sv
// Width constants and shared types for the pipelined 32x32 -> 64 unsigned multiplier.
package multiplier_pkg;

  localparam int unsigned OP_W   = 32;  // operand width
  localparam int unsigned HALF_W = 16;  // operand half width
  localparam int unsigned PROD_W = 64;  // full product width
  localparam int unsigned PP_W   = 32;  // partial product width

  typedef logic [OP_W-1:0]   operand_t;
  typedef logic [HALF_W-1:0] half_t;
  typedef logic [PP_W-1:0]   pp_t;
  typedef logic [PROD_W-1:0] product_t;

endpackage

// File: rtl/pipelined_multiplier_if.sv
// Operand/result bundle for pipelined_multiplier.
//   a, b : operands, driven by the master, sampled by the multiplier
//   r    : registered product, driven by the multiplier
interface pipelined_multiplier_if;
  import multiplier_pkg::*;

  operand_t a;
  operand_t b;
  product_t r;

  modport master (output a, output b, input r);
  modport slave  (input a, input b, output r);

endinterface

// File: rtl/mul16x16.sv
// Combinational unsigned 16x16 -> 32 multiplier.
//   x, y : 16-bit unsigned operands
//   p    : 32-bit exact product
module mul16x16
  import multiplier_pkg::*;
(
  input  half_t x,
  input  half_t y,
  output pp_t   p
);

  // Both operands are widened first so the product is evaluated at full width.
  assign p = pp_t'(x) * pp_t'(y);

endmodule

// File: rtl/pipelined_multiplier.sv
// Two-stage pipelined 32x32 -> 64 unsigned multiplier, one product per cycle.
// Stage 1 registers the four 16x16 partial products; stage 2 sums them into r.
// A product appears on r one edge after the edge that sampled its operands.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, clears stage 1 and r
//   bus : a, b operands in; r product out (slave side)
module pipelined_multiplier
  import multiplier_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  pipelined_multiplier_if.slave        bus
);

  half_t a_h, a_l, b_h, b_l;
  pp_t   pll_d, plh_d, phl_d, phh_d;
  pp_t   pll_q, plh_q, phl_q, phh_q;

  logic [PP_W:0] mid_sum;  // pLH + pHL needs one extra bit for the carry
  product_t      r_d, r_q;

  assign a_h = bus.a[OP_W-1:HALF_W];
  assign a_l = bus.a[HALF_W-1:0];
  assign b_h = bus.b[OP_W-1:HALF_W];
  assign b_l = bus.b[HALF_W-1:0];

  mul16x16 u_mul_ll (.x(a_l), .y(b_l), .p(pll_d));
  mul16x16 u_mul_lh (.x(a_l), .y(b_h), .p(plh_d));
  mul16x16 u_mul_hl (.x(a_h), .y(b_l), .p(phl_d));
  mul16x16 u_mul_hh (.x(a_h), .y(b_h), .p(phh_d));

  always_ff @(posedge clk) begin
    if (rst) begin
      pll_q <= '0;
      plh_q <= '0;
      phl_q <= '0;
      phh_q <= '0;
      r_q   <= '0;
    end else begin
      pll_q <= pll_d;
      plh_q <= plh_d;
      phl_q <= phl_d;
      phh_q <= phh_d;
      r_q   <= r_d;
    end
  end

  always_comb begin
    mid_sum = {1'b0, plh_q} + {1'b0, phl_q};
    // pHH<<32 and pLL occupy disjoint bits, so they concatenate instead of adding.
    r_d     = {phh_q, pll_q} + {{(PROD_W-PP_W-1-HALF_W){1'b0}}, mid_sum, {HALF_W{1'b0}}};
  end

  assign bus.r = r_q;

endmodule

// File: tb/tb_pipelined_multiplier.sv
module tb_pipelined_multiplier;
  import multiplier_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipelined_multiplier_if bus ();

  pipelined_multiplier dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: pend is the product of the operands taken at the most recent
  // edge; exp_r is what r must show after that edge. Reset zeroes both.
  product_t pend  = '0;
  product_t exp_r = '0;

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      exp_r = '0;
      pend  = '0;
    end else begin
      exp_r = pend;
      pend  = product_t'(bus.a) * product_t'(bus.b);
    end
    #1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    bus.a = '0;
    bus.b = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (bus.r !== 64'h0) begin
        bad++;
        $display("FAIL reset_hold[%0d]: got %h want %h", i, bus.r, 64'h0);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (bus.r !== 64'h0) begin
        bad++;
        $display("FAIL zero_after_reset[%0d]: got %h want %h", i, bus.r, 64'h0);
      end
    end
  endtask

  // Corner operands applied back to back, each for one cycle.
  task automatic test_corners();
    operand_t ca[6];
    operand_t cb[6];
    product_t ce[6];
    ca[0] = 32'h1;                     cb[0] = 32'hFFFF_FFFF; ce[0] = 64'h0000_0000_FFFF_FFFF;
    ca[1] = 32'hFFFF_FFFF;             cb[1] = 32'hFFFF_FFFF; ce[1] = 64'hFFFF_FFFE_0000_0001;
    ca[2] = 32'h0001_0000;             cb[2] = 32'h0001_0000; ce[2] = 64'h0000_0001_0000_0000;
    ca[3] = 32'hFFFF_0000 | 32'hFFFF;  cb[3] = 32'h0000_FFFF | 32'hFFFF_0000;
    ce[3] = 64'hFFFF_FFFE_0000_0001;
    ca[4] = 32'h0000_FFFF;             cb[4] = 32'hFFFF_0000; ce[4] = 64'h0000_FFFE_0001_0000;
    ca[5] = 32'hFFFF_0000;             cb[5] = 32'h0000_FFFF; ce[5] = 64'h0000_FFFE_0001_0000;
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) begin
        bus.a = ca[i];
        bus.b = cb[i];
      end else begin
        bus.a = $urandom;
        bus.b = $urandom;
      end
      tick();
      if (i > 0) begin
        total++;
        if (bus.r !== ce[i-1]) begin
          bad++;
          $display("FAIL corner[%0d]: got %h want %h", i - 1, bus.r, ce[i-1]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    operand_t sa = '0;
    operand_t sb = '0;
    for (int i = 0; i < 10000; i++) begin
      bus.a = sa;
      bus.b = sb;
      tick();
      total++;
      if (bus.r !== exp_r) begin
        bad++;
        $display("FAIL stream[%0d]: got %h want %h", i, bus.r, exp_r);
      end
      sa = sa + 32'h2345_6789;
      sb = sb + 32'h3456_7891;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      bus.a = $urandom;
      bus.b = $urandom;
      tick();
      total++;
      if (bus.r !== exp_r) begin
        bad++;
        $display("FAIL random[%0d]: got %h want %h", i, bus.r, exp_r);
      end
    end
  endtask

  task automatic test_mid_reset();
    operand_t fa, fb;
    product_t want;
    for (int i = 0; i < 20; i++) begin
      bus.a = $urandom;
      bus.b = $urandom;
      tick();
    end
    // Nonzero operands and a nonzero in-flight product are present when reset hits.
    rst   = 1'b1;
    bus.a = $urandom | 32'h1;
    bus.b = $urandom | 32'h1;
    tick();
    total++;
    if (bus.r !== 64'h0) begin
      bad++;
      $display("FAIL mid_reset_edge: got %h want %h", bus.r, 64'h0);
    end
    rst   = 1'b0;
    fa    = $urandom | 32'h1;
    fb    = $urandom | 32'h1;
    bus.a = fa;
    bus.b = fb;
    want  = product_t'(fa) * product_t'(fb);
    tick();
    total++;
    if (bus.r !== 64'h0) begin
      bad++;
      $display("FAIL mid_reset_first_edge: got %h want %h", bus.r, 64'h0);
    end
    bus.a = $urandom;
    bus.b = $urandom;
    tick();
    total++;
    if (bus.r !== want) begin
      bad++;
      $display("FAIL mid_reset_resume: got %h want %h", bus.r, want);
    end
    for (int i = 0; i < 10; i++) begin
      bus.a = $urandom;
      bus.b = $urandom;
      tick();
      total++;
      if (bus.r !== exp_r) begin
        bad++;
        $display("FAIL after_mid_reset[%0d]: got %h want %h", i, bus.r, exp_r);
      end
    end
  endtask

  initial begin
    bus.a = '0;
    bus.b = '0;
    test_reset();
    test_corners();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
